// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes RISC-V ALU operations into ALUop codes and issues
// them through a valid/ready handshake. Single-cycle ops appear one cycle after
// acceptance; multiply/divide ops occupy a countdown before their result.
// Optional feature macro: ALU_ISSUE_MDU_EN enables multiply/divide decode
// (codes 16..23). Without it those encodings are illegal and busy stays 0.
module alu_issue_ctrl #(
    parameter int OPW        = 5,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [6:0]     opcode,
    input  logic [2:0]     funct,
    input  logic [6:0]     funct7,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] ALUop,
    output logic           illegal,
    output logic           busy
);

    // Legacy ALUop.vh codes, zero-extended to OPW
    localparam logic [OPW-1:0] ALU_ADD    = OPW'(0);
    localparam logic [OPW-1:0] ALU_SUB    = OPW'(1);
    localparam logic [OPW-1:0] ALU_AND    = OPW'(2);
    localparam logic [OPW-1:0] ALU_OR     = OPW'(3);
    localparam logic [OPW-1:0] ALU_XOR    = OPW'(4);
    localparam logic [OPW-1:0] ALU_SLT    = OPW'(5);
    localparam logic [OPW-1:0] ALU_SLTU   = OPW'(6);
    localparam logic [OPW-1:0] ALU_SLL    = OPW'(7);
    localparam logic [OPW-1:0] ALU_SRA    = OPW'(8);
    localparam logic [OPW-1:0] ALU_SRL    = OPW'(9);
    localparam logic [OPW-1:0] ALU_COPY_B = OPW'(10);
    localparam logic [OPW-1:0] ALU_XXX    = OPW'(15);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // Countdown preload is N-1; zero means the op completes single-cycle
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [3:0]       count;
    logic [OPW-1:0]   pend_op;
    logic [OPW-1:0]   dec_op;
    logic             dec_illegal;
    logic             dec_mul;
    logic             dec_div;
    logic [3:0]       dec_load;
    logic             accept;

    // Base integer ops shared by R and I formats; alt selects SUB / SRA
    function automatic logic [OPW-1:0] base_op(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  base_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

    // Instruction decode: unsupported encodings fall through to ALU_XXX/illegal
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        dec_op      = ALU_XXX;
        dec_illegal = 1'b1;
        dec_mul     = 1'b0;
        dec_div     = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000) begin
                    dec_op      = base_op(funct, 1'b0);
                    dec_illegal = 1'b0;
                end else if (funct7 == 7'b0100000 && (funct == 3'b000 || funct == 3'b101)) begin
                    dec_op      = base_op(funct, 1'b1);
                    dec_illegal = 1'b0;
                end
`ifdef ALU_ISSUE_MDU_EN
                else if (funct7 == 7'b0000001) begin
                    dec_op      = OPW'(16 + int'(funct));
                    dec_illegal = 1'b0;
                    dec_mul     = ~funct[2];
                    dec_div     = funct[2];
                end
`endif
            end
            OP_I: begin
                // funct7[5] only distinguishes SRLI/SRAI; ADDI has no SUB form
                dec_op      = base_op(funct, funct7[5] && (funct == 3'b101));
                dec_illegal = 1'b0;
            end
            OP_LUI: begin
                dec_op      = ALU_COPY_B;
                dec_illegal = 1'b0;
            end
            OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_AUIPC: begin
                dec_op      = ALU_ADD;
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    assign dec_load = dec_mul ? MUL_LOAD : (dec_div ? DIV_LOAD : 4'd0);
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: enter BUSY on a multi-cycle accept, leave when countdown expires
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && dec_load != 4'd0) state_nxt = BUSY;
            BUSY:    if (count <= 4'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Handshake outputs derived from state; flush always wins over in_valid
    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
`ifdef ALU_ISSUE_MDU_EN
        busy     = (state == BUSY);
`else
        busy     = 1'b0;
`endif
    end

    // Result register, countdown and pending multi-cycle op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            ALUop     <= ALU_XXX;
            illegal   <= 1'b0;
            count     <= 4'd0;
            pend_op   <= ALU_XXX;
        end else if (flush) begin
            out_valid <= 1'b0;
            count     <= 4'd0;
        end else if (accept) begin
            if (dec_load == 4'd0) begin
                out_valid <= 1'b1;
                ALUop     <= dec_op;
                illegal   <= dec_illegal;
            end else begin
                // Previous result is consumed in this same cycle
                out_valid <= 1'b0;
                pend_op   <= dec_op;
                count     <= dec_load;
            end
        end else if (state == BUSY) begin
            if (count != 4'd0) count <= count - 4'd1;
            if (count <= 4'd1) begin
                out_valid <= 1'b1;
                ALUop     <= pend_op;
                illegal   <= 1'b0;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
